// File: rtl/tt_trng_collector.sv
// rtl/tt_trng_collector.sv - inverter-ring TRNG collector: warm-up, von Neumann debias, word packing, repetition test
// Optional TRNG_DISCARD_CNT_EN adds a saturating discard_cnt of rejected 00/11 pairs.
module tt_trng_collector #(
  parameter int WORD_W    = 8,
  parameter int WARMUP    = 16,
  parameter int REP_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              raw_bit,
  output logic              startring,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              rd_ready,
  output logic              health_fail
`ifdef TRNG_DISCARD_CNT_EN
  ,
  output logic [15:0]       discard_cnt
`endif
);

  localparam int CW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        warm_cnt;
  logic              phase;
  logic              first_bit;
  logic              prev_bit;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_nx;
  logic [CW-1:0]     bit_cnt;
  logic [7:0]        rep_cnt;
  logic [7:0]        rep_nx;
  logic              pair_useful;
  logic              pair_discard;
  logic              word_done;
  logic              rep_trip;
  logic              warm_done;

  always_comb begin
    pair_useful  = phase && (first_bit != raw_bit);
    pair_discard = phase && (first_bit == raw_bit);
    shift_nx     = {shift_q[WORD_W-2:0], first_bit};
    word_done    = (state == S_COLLECT) && pair_useful && (bit_cnt == CW'(WORD_W - 1));
    warm_done    = (warm_cnt == 8'(WARMUP - 1));
    // rep_cnt==0 marks the first sample after warm-up
    if (rep_cnt == 8'd0 || raw_bit != prev_bit)
      rep_nx = 8'd1;
    else if (rep_cnt >= 8'(REP_LIMIT))
      rep_nx = rep_cnt;
    else
      rep_nx = rep_cnt + 8'd1;
    rep_trip = (state == S_COLLECT) && (rep_nx == 8'(REP_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Priority in COLLECT: health trip, then abort, then word completion
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (enable) state_nx = S_WARMUP;
      S_WARMUP:  if (!enable) state_nx = S_IDLE;
                 else if (warm_done) state_nx = S_COLLECT;
      S_COLLECT: if (rep_trip) state_nx = S_FAIL;
                 else if (!enable) state_nx = S_IDLE;
                 else if (word_done) state_nx = S_HOLD;
      S_HOLD:    if (!enable) state_nx = S_IDLE;
                 else if (rd_ready) state_nx = S_COLLECT;
      S_FAIL:    state_nx = S_FAIL;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    startring   = (state == S_WARMUP) || (state == S_COLLECT) || (state == S_HOLD);
    word_valid  = (state == S_HOLD);
    health_fail = (state == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt  <= 8'd0;
      phase     <= 1'b0;
      first_bit <= 1'b0;
      prev_bit  <= 1'b0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= 8'd0;
      word_out  <= '0;
    end else begin
      warm_cnt <= (state == S_WARMUP) ? warm_cnt + 8'd1 : 8'd0;
      case (state)
        S_COLLECT: begin
          phase    <= ~phase;
          prev_bit <= raw_bit;
          rep_cnt  <= rep_nx;
          if (!phase) begin
            first_bit <= raw_bit;
          end else if (pair_useful) begin
            shift_q <= shift_nx;
            bit_cnt <= bit_cnt + CW'(1);
          end
          if (state_nx == S_HOLD)
            word_out <= shift_nx;
        end
        // Repetition history survives HOLD; the word assembly restarts
        S_HOLD: begin
          phase   <= 1'b0;
          bit_cnt <= '0;
          shift_q <= '0;
        end
        default: begin
          phase   <= 1'b0;
          bit_cnt <= '0;
          shift_q <= '0;
          rep_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef TRNG_DISCARD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      discard_cnt <= 16'd0;
    else if (state == S_COLLECT && pair_discard && discard_cnt != 16'hFFFF)
      discard_cnt <= discard_cnt + 16'd1;
  end
`else
  logic unused_discard;
  assign unused_discard = pair_discard;
`endif

endmodule

// File: tb/tb_tt_trng_collector.sv
// tb/tb_tt_trng_collector.sv - scoreboard bench for tt_trng_collector
module tb_tt_trng_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       raw_bit;
  logic       startring;
  logic [7:0] word_out;
  logic       word_valid;
  logic       rd_ready;
  logic       health_fail;
`ifdef TRNG_DISCARD_CNT_EN
  logic [15:0] discard_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  tt_trng_collector #(.WORD_W(8), .WARMUP(16), .REP_LIMIT(32)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .raw_bit(raw_bit),
    .startring(startring),
    .word_out(word_out),
    .word_valid(word_valid),
    .rd_ready(rd_ready),
    .health_fail(health_fail)
`ifdef TRNG_DISCARD_CNT_EN
    ,
    .discard_cnt(discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b);
    raw_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [1:0] p);
    step(p[1]);
    step(p[0]);
  endtask

  task automatic warmup_junk();
    for (int i = 0; i < 16; i++) step(i[0]);
  endtask

  // Monitor: every handshake must match the oldest expected word
  always @(negedge clk) begin
    if (word_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %0h expected none", word_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (word_out !== e) begin
          errors++;
          $display("FAIL word_data: got %0h expected %0h", word_out, e);
        end
      end
    end
  end

  initial begin
    logic [1:0] w1[8];
    logic [1:0] w3[8];
    logic       stable;
    w1 = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    w3 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1; enable = 1'b0; rd_ready = 1'b0; raw_bit = 1'b0;
    step(0); step(0);
    rst = 1'b0;
    chk("rst_startring", startring, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_health_fail", health_fail, 0);
    chk("rst_word_out", word_out, 0);

    // Warm-up then word 8'hB2
    enable = 1'b1;
    step(0);
    chk("startring_on", startring, 1);
    warmup_junk();
    exp_q.push_back(8'hB2);
    for (int i = 0; i < 7; i++) pair(w1[i]);
    chk("valid_early", word_valid, 0);
    pair(w1[7]);
    chk("valid_latency", word_valid, 1);
    chk("word_b2", word_out, 8'hB2);

    // Backpressure
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      if (word_out !== 8'hB2 || word_valid !== 1'b1) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    rd_ready = 1'b1;
    step(0);
    rd_ready = 1'b0;
    chk("valid_drop", word_valid, 0);
    chk("word_kept", word_out, 8'hB2);

    // Discarded pairs
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) begin
      pair(2'b00); pair(2'b11); pair(2'b10);
    end
    chk("ff_valid", word_valid, 1);
`ifdef TRNG_DISCARD_CNT_EN
    chk("discard_cnt", discard_cnt, 16);
`endif
    rd_ready = 1'b1;
    step(0);
    rd_ready = 1'b0;

    // Abort after 5 useful bits
    for (int i = 0; i < 5; i++) pair(2'b10);
    enable = 1'b0;
    step(0);
    chk("abort_startring", startring, 0);
    chk("abort_valid", word_valid, 0);
    enable = 1'b1;
    step(0);
    chk("restart_startring", startring, 1);
    warmup_junk();
    exp_q.push_back(8'h35);
    for (int i = 0; i < 8; i++) pair(w3[i]);
    chk("new_word_valid", word_valid, 1);
    // Reset while in HOLD
    rst = 1'b1; rd_ready = 1'b1;
    step(0);
    rst = 1'b0; rd_ready = 1'b0;
    chk("hold_rst_valid", word_valid, 0);
    chk("hold_rst_startring", startring, 0);

    // Health test
    enable = 1'b1;
    step(0);
    warmup_junk();
    for (int i = 0; i < 31; i++) step(1'b1);
    chk("health_not_yet", health_fail, 0);
    step(1'b1);
    chk("health_fail", health_fail, 1);
    chk("fail_startring", startring, 0);
    chk("fail_valid", word_valid, 0);
    enable = 1'b0;
    step(0); step(0);
    enable = 1'b1;
    step(0); step(1);
    chk("fail_sticky", health_fail, 1);
    chk("fail_ring_off", startring, 0);
    rst = 1'b1;
    step(0);
    rst = 1'b0; enable = 1'b0;
    chk("clr_health", health_fail, 0);
    chk("clr_startring", startring, 0);
    chk("clr_valid", word_valid, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_trng_collector.md
Name: tt_trng_collector

Overview:
- Consumer end of the inverter-ring entropy source: drives the ring's start control and samples its registered raw XOR bit once per clock.
- Discards ring warm-up samples and removes bias with von Neumann pairing.
- Packs debiased bits into WORD_W-bit words behind a valid/ready output handshake.
- Runs a repetition-count health test; a stuck source raises a sticky alarm and stops the ring.

Parameters:
- WORD_W, 8, output word width in bits (2..32).
- WARMUP, 16, clk cycles of raw_bit discarded after startring rises (1..255).
- REP_LIMIT, 32, identical consecutive raw samples that trip health_fail (2..255).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  request entropy collection; level sensitive.
- raw_bit  input  1  registered raw random bit from the ring block, one sample per cycle.
- startring  output  1  ring oscillate enable, registered.
- word_out  output  WORD_W  packed random word; stable while word_valid=1.
- word_valid  output  1  word_out holds an unconsumed word.
- rd_ready  input  1  consumer accepts; transfer occurs on a cycle with word_valid & rd_ready.
- health_fail  output  1  sticky repetition-test alarm.

Behaviour:
- Reset: startring=0, word_out=0, word_valid=0, health_fail=0; state IDLE; all counters, shift register and pair phase cleared.
- States are IDLE, WARMUP, COLLECT, HOLD and FAIL.
- IDLE:
  - startring=0.
  - enable=1 -> WARMUP; startring goes 1 on that same edge.
- WARMUP:
  - startring=1; raw_bit ignored.
  - Counts WARMUP cycles, then -> COLLECT with pair phase=0, bit count=0 and rep counter=0.
- COLLECT, raw_bit sampled every cycle:
  - Phase 0: store raw_bit as first.
  - Phase 1: if first!=raw_bit, shift first into the LSB of the shift register (shift left) and increment bit count. Pair 10 emits 1, pair 01 emits 0. Pairs 00 and 11 are discarded.
  - Phase toggles every COLLECT cycle.
  - When bit count reaches WORD_W: word_out is loaded with the completed word, word_valid=1 on the next edge, -> HOLD. Latency is 1 clk from the second bit of the last useful pair.
- HOLD:
  - Sampling paused; startring stays 1.
  - word_valid & rd_ready -> word_valid=0 next cycle, -> COLLECT with phase=0, bit count=0, shift register=0.
  - word_out holds its value after the transfer, until the next load.
- Repetition test:
  - Active only in COLLECT.
  - Rep counter is 1 on the first sample. It increments (saturating at REP_LIMIT) when raw_bit equals the previous sample and reloads to 1 otherwise.
  - Reaching REP_LIMIT -> FAIL on the next edge.
- FAIL:
  - health_fail=1, startring=0, word_valid=0.
  - enable is ignored; only rst exits FAIL.
- enable=0 in WARMUP, COLLECT or HOLD:
  - -> IDLE next edge; startring=0; partial word dropped; word_valid cleared (abort, word lost).
  - A handshake in the same cycle still counts as a transfer.
- Simultaneous events:
  - Health trip on the same cycle as word completion: FAIL wins and word_valid never asserts.
  - enable=0 on the same cycle as a health trip: FAIL wins.
- rst asserted in any state restores the reset values on the next edge, including mid-word and in FAIL.

Optional Feature:
- Macro: TRNG_DISCARD_CNT_EN.
- When defined:
  - Adds output discard_cnt[15:0]: saturating count of discarded 00/11 pairs in COLLECT.
  - Cleared by rst only; holds its value at 16'hFFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Warm-up and output word: rst, then enable=1 with WARMUP=16. Next, feed pairs 10,01,10,10,01,01,10,01 with rd_ready=0.
  - Required: startring=1 one edge after enable; the first 16 samples are ignored.
  - Required: word_valid=1 one clk after the last pair, with word_out=8'hB2, held until rd_ready.
- Discarded pairs: feed 00,11,10 repeated 8 times.
  - Required: word_out=8'hFF; with TRNG_DISCARD_CNT_EN, discard_cnt=16.
- Backpressure: hold rd_ready=0 for 50 cycles in HOLD, then pulse it for 1 cycle.
  - Required: word_out stable throughout, word_valid falls the next edge, and collection restarts from bit 0.
- Health test: in COLLECT, drive raw_bit=1 for 32 cycles (REP_LIMIT=32).
  - Required: health_fail=1, startring=0, word_valid=0; toggling enable has no effect; rst clears all three.
- Abort and reset: deassert enable after 5 useful bits, then re-enable and feed one full word.
  - Required: word_out contains only the new 8 bits.
  - Then assert rst in HOLD: word_valid=0 and startring=0 next edge.
